// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux channel: owns the mux select, grants one
// requester at a time, bounds contested bursts and inserts a dead cycle at each handover.
module mux_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GNT_A  = 2'd1;
    localparam logic [1:0] S_GNT_B  = 2'd2;
    localparam logic [1:0] S_SWITCH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_a_q, last_a_d;
    logic             sel_q, sel_d;
    logic             gnt_a_q, gnt_b_q;
    logic             enter_a, enter_b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_a && (!req_b || !last_a_q))
                    state_d = S_GNT_A;
                else if (req_b && (!req_a || last_a_q))
                    state_d = S_GNT_B;
            end
            S_GNT_A: begin
                if (done_a || !req_a || (cnt_q == CNT_MAX && req_b))
                    state_d = S_SWITCH;
            end
            S_GNT_B: begin
                if (done_b || !req_b || (cnt_q == CNT_MAX && req_a))
                    state_d = S_SWITCH;
            end
            S_SWITCH: begin
                // The side that did not go last gets first claim on the channel.
                if (last_a_q) begin
                    if (req_b)      state_d = S_GNT_B;
                    else if (req_a) state_d = S_GNT_A;
                    else            state_d = S_IDLE;
                end else begin
                    if (req_a)      state_d = S_GNT_A;
                    else if (req_b) state_d = S_GNT_B;
                    else            state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_a = (state_d == S_GNT_A) && (state_q != S_GNT_A);
    assign enter_b = (state_d == S_GNT_B) && (state_q != S_GNT_B);

    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        last_a_d = last_a_q;
        if (enter_a || enter_b) begin
            cnt_d    = '0;
            sel_d    = enter_a;
            last_a_d = enter_a;
        end else if ((state_q == S_GNT_A || state_q == S_GNT_B) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_a_q <= 1'b0;
            sel_q    <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_a_q <= last_a_d;
            sel_q    <= sel_d;
            gnt_a_q  <= (state_d == S_GNT_A);
            gnt_b_q  <= (state_d == S_GNT_B);
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign sel   = sel_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: table vectors through a scoreboard queue, hand sequences for
// reset, bursts, saturation and MAX_BURST=1, plus continuous grant/select monitors.
module tb_mux_arbiter;

    logic clk, rst;
    logic req_a, req_b, done_a, done_b;
    logic gnt_a, gnt_b, sel, busy;
    logic req_a1, req_b1;
    logic gnt_a1, gnt_b1, sel1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] in;   // {req_a, req_b, done_a, done_b}
        logic [3:0] exp;  // {gnt_a, gnt_b, sel, busy} after the sampling edge
        string      name;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb_q[$];
    logic       sel_prev, sel1_prev;

    mux_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .done_a(done_a), .done_b(done_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .busy(busy)
    );

    mux_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_a(req_a1), .req_b(req_b1),
        .done_a(1'b0), .done_b(1'b0),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Continuous invariants, sampled on the falling edge.
    always @(negedge clk) begin
        n_checks++;
        if ((gnt_a && gnt_b) || (gnt_a1 && gnt_b1)) begin
            n_fail++;
            $display("FAIL gnt_overlap: gnt_a=%b gnt_b=%b gnt_a1=%b gnt_b1=%b required no overlap",
                     gnt_a, gnt_b, gnt_a1, gnt_b1);
        end
        if (!rst && !gnt_a && !gnt_b) begin
            n_checks++;
            if (sel !== sel_prev) begin
                n_fail++;
                $display("FAIL sel_stable: sel=%b required %b while no grant", sel, sel_prev);
            end
        end
        if (!rst && !gnt_a1 && !gnt_b1) begin
            n_checks++;
            if (sel1 !== sel1_prev) begin
                n_fail++;
                $display("FAIL sel1_stable: sel=%b required %b while no grant", sel1, sel1_prev);
            end
        end
        sel_prev  = sel;
        sel1_prev = sel1;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {gnt_a,gnt_b,sel,busy} actual=%b required=%b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic apply(input logic [3:0] in_v, input logic [3:0] exp_v, input string name);
        logic [3:0] e;
        {req_a, req_b, done_a, done_b} = in_v;
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(name, {gnt_a, gnt_b, sel, busy}, e);
    endtask

    task automatic add(input logic [3:0] in_v, input logic [3:0] exp_v, input string name);
        vec_t v;
        v.in   = in_v;
        v.exp  = exp_v;
        v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        // basic grant/done, done ignored while not granted, SWITCH fallbacks, ties
        add(4'b1000, 4'b1011, "t2_grant_a");
        add(4'b1000, 4'b1011, "t2_hold_a1");
        add(4'b1000, 4'b1011, "t2_hold_a2");
        add(4'b1000, 4'b1011, "t2_hold_a3");
        add(4'b1000, 4'b1011, "t2_hold_a4");
        add(4'b1010, 4'b0011, "t2_done_a_switch");
        add(4'b0000, 4'b0010, "t2_idle_busy0");
        add(4'b0100, 4'b0101, "b_alone_grant");
        add(4'b0110, 4'b0101, "done_a_ignored");
        add(4'b0101, 4'b0001, "done_b_switch");
        add(4'b0100, 4'b0101, "switch_back_last");
        add(4'b0000, 4'b0001, "req_b_drop");
        add(4'b1100, 4'b1011, "switch_other_first");
        add(4'b0100, 4'b0011, "req_a_drop");
        add(4'b1100, 4'b0101, "switch_to_b");
        add(4'b0000, 4'b0001, "release_b");
        add(4'b0000, 4'b0000, "idle_sel_hold");
        add(4'b1100, 4'b1011, "idle_tie_a");
        add(4'b0000, 4'b0011, "release_a");
        add(4'b0000, 4'b0010, "idle_after_a");
        add(4'b1100, 4'b0101, "idle_tie_b");
        add(4'b0000, 4'b0001, "release_b2");
        add(4'b0000, 4'b0000, "idle_again");
        // done_a together with burst expiry while B waits
        add(4'b1000, 4'b1011, "t5_grant_a");
        for (int i = 0; i < 7; i++) add(4'b1100, 4'b1011, "t5_hold_a");
        add(4'b1110, 4'b0011, "t5_single_switch");
        add(4'b1100, 4'b0101, "t5_grant_b");
        add(4'b0000, 4'b0001, "t5_release");
        add(4'b0000, 4'b0000, "t5_idle");

        rst = 1'b1;
        {req_a, req_b, done_a, done_b} = 4'b0000;
        req_a1 = 1'b0;
        req_b1 = 1'b0;
        sel_prev  = 1'b0;
        sel1_prev = 1'b0;
        #3;
        check("reset_state", {gnt_a, gnt_b, sel, busy}, 4'b0000);
        check("reset_state_mb1", {gnt_a1, gnt_b1, sel1, busy1}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // async reset mid-grant, then the first tie goes to A
        apply(4'b1000, 4'b1011, "t1_grant_a");
        rst = 1'b1;
        #2;
        check("t1_async_clear", {gnt_a, gnt_b, sel, busy}, 4'b0000);
        {req_a, req_b, done_a, done_b} = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(4'b1100, 4'b1011, "t1_tie_after_rst");
        apply(4'b0000, 4'b0011, "t1_release");
        apply(4'b0000, 4'b0010, "t1_idle");

        foreach (tbl[i]) apply(tbl[i].in, tbl[i].exp, tbl[i].name);

        // contested bursts: 8 A, dead, 8 B, dead, repeating
        for (int k = 0; k < 36; k++) begin
            int ph;
            logic [3:0] e;
            ph = k % 18;
            if (ph < 8)       e = 4'b1011;
            else if (ph == 8) e = 4'b0011;
            else if (ph < 17) e = 4'b0101;
            else              e = 4'b0001;
            apply(4'b1100, e, $sformatf("t3_burst_%0d", k));
        end
        apply(4'b0000, 4'b0000, "t3_idle");

        // uncontested hold saturates; a late B request then switches at once
        for (int k = 0; k < 20; k++) apply(4'b1000, 4'b1011, $sformatf("t4_hold_%0d", k));
        apply(4'b1100, 4'b0011, "t4_saturated_switch");
        apply(4'b1100, 4'b0101, "t4_grant_b");
        apply(4'b0000, 4'b0001, "t4_release");
        apply(4'b0000, 4'b0000, "t4_idle");

        // MAX_BURST=1: contested grants last exactly one cycle
        req_a1 = 1'b1;
        req_b1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] e;
            case (k % 4)
                0:       e = 4'b1011;
                1:       e = 4'b0011;
                2:       e = 4'b0101;
                default: e = 4'b0001;
            endcase
            @(posedge clk);
            #1;
            check($sformatf("mb1_cycle_%0d", k), {gnt_a1, gnt_b1, sel1, busy1}, e);
        end
        req_a1 = 1'b0;
        req_b1 = 1'b0;
        @(posedge clk);
        #1;

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
